// File: rtl/div_unit_seq.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with a
// start/busy/done handshake; one quotient bit per cycle in CALC.
module div_unit_seq #(
  parameter int         WIDTH  = 32,
  parameter logic [4:0] OPDIV  = 5'd12,
  parameter logic [4:0] OPDIVU = 5'd13,
  parameter logic [4:0] OPREM  = 5'd14,
  parameter logic [4:0] OPREMU = 5'd15
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iStart,
  input  logic [4:0]       iControl,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iFlush,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResult
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             is_rem_q, is_rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             is_div_op, is_signed, is_rem_op, a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_sh, rem_diff;
  logic             ge;
  logic [WIDTH-1:0] rem_step, quo_step, fixed_res;

  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves a variable unassigned (no latches).
    state_d   = state_q;
    result_d  = result_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;

    is_div_op = (iControl == OPDIV) || (iControl == OPDIVU) ||
                (iControl == OPREM) || (iControl == OPREMU);
    is_signed = (iControl == OPDIV) || (iControl == OPREM);
    is_rem_op = (iControl == OPREM) || (iControl == OPREMU);
    a_neg     = is_signed && iA[WIDTH-1];
    b_neg     = is_signed && iB[WIDTH-1];
    // The most negative value negates to itself, which is its correct unsigned magnitude.
    abs_a     = a_neg ? (~iA + 1'b1) : iA;
    abs_b     = b_neg ? (~iB + 1'b1) : iB;

    // Partial remainder needs one extra bit: an unsigned divisor may use the full width.
    rem_sh    = {rem_q, quo_q[WIDTH-1]};
    rem_diff  = rem_sh - {1'b0, divisor_q};
    ge        = (rem_sh >= {1'b0, divisor_q});
    rem_step  = ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_step  = {quo_q[WIDTH-2:0], ge};
    if (is_rem_q) fixed_res = neg_rem_q ? (~rem_step + 1'b1) : rem_step;
    else          fixed_res = neg_quo_q ? (~quo_step + 1'b1) : quo_step;

    unique case (state_q)
      IDLE: begin
        if (!iFlush && iStart && is_div_op) begin
          is_rem_d  = is_rem_op;
          neg_quo_d = (a_neg ^ b_neg) && (iB != '0);
          neg_rem_d = a_neg;
          divisor_d = abs_b;
          if (iB == '0) begin
            result_d = is_rem_op ? iA : '1;
            state_d  = DONE;
          end else if (is_signed && (iA == MIN_NEG) && (iB == '1)) begin
            result_d = is_rem_op ? '0 : iA;
            state_d  = DONE;
          end else begin
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = abs_a;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (iFlush) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            result_d = fixed_res;
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Handshake outputs are flops fed from the next state, keeping them glitch-free.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign oBusy   = busy_q;
  assign oDone   = done_q;
  assign oResult = result_q;

endmodule

// File: tb/tb_div_unit_seq.sv
// Directed bench for div_unit_seq: table of hand-computed vectors plus
// sequences for flush, reset mid-operation and ignored starts.
module tb_div_unit_seq;

  localparam int         W      = 32;
  localparam logic [4:0] OPADD  = 5'd0;
  localparam logic [4:0] OPDIV  = 5'd12;
  localparam logic [4:0] OPDIVU = 5'd13;
  localparam logic [4:0] OPREM  = 5'd14;
  localparam logic [4:0] OPREMU = 5'd15;
  localparam int         LAT_N  = W + 1;
  localparam int         LAT_S  = 1;

  logic         iCLK = 1'b0;
  logic         iRST_n = 1'b0;
  logic         iStart = 1'b0;
  logic [4:0]   iControl = OPADD;
  logic [W-1:0] iA = '0;
  logic [W-1:0] iB = '0;
  logic         iFlush = 1'b0;
  logic         oBusy, oDone;
  logic [W-1:0] oResult;

  int errors = 0;
  int checks = 0;

  div_unit_seq #(.WIDTH(W), .OPDIV(OPDIV), .OPDIVU(OPDIVU), .OPREM(OPREM), .OPREMU(OPREMU)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iStart(iStart), .iControl(iControl),
    .iA(iA), .iB(iB), .iFlush(iFlush),
    .oBusy(oBusy), .oDone(oDone), .oResult(oResult)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    string       name;
    logic [4:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    @(negedge iCLK);
    iControl = ctrl; iA = a; iB = b; iStart = 1'b1;
    @(posedge iCLK); #1;
    iStart = 1'b0;
    iA = 32'hDEAD_BEEF;
    iB = 32'h1234_5678;
  endtask

  // Leaves the bench one edge after oDone, i.e. in the earliest cycle a new start is accepted.
  task automatic wait_done(input int start_lat, output logic [31:0] res, output int lat);
    lat = start_lat;
    while (!oDone && lat < 100) begin
      @(posedge iCLK); #1;
      lat++;
    end
    if (!oDone) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no oDone after %0d cycles expected oDone", lat);
    end
    res = oResult;
    @(posedge iCLK); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] res, prior;
    int          lat;
    bit          done_seen;

    vecs[0]  = '{"divu_100_7",   OPDIVU, 32'd100,       32'd7,         32'd14,        LAT_N};
    vecs[1]  = '{"remu_100_7",   OPREMU, 32'd100,       32'd7,         32'd2,         LAT_N};
    vecs[2]  = '{"div_m7_2",     OPDIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT_N};
    vecs[3]  = '{"rem_m7_2",     OPREM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_N};
    vecs[4]  = '{"rem_7_m2",     OPREM,  32'd7,         32'hFFFF_FFFE, 32'd1,         LAT_N};
    vecs[5]  = '{"div_7_m2",     OPDIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_N};
    vecs[6]  = '{"div_5_0",      OPDIV,  32'd5,         32'd0,         32'hFFFF_FFFF, LAT_S};
    vecs[7]  = '{"remu_5_0",     OPREMU, 32'd5,         32'd0,         32'd5,         LAT_S};
    vecs[8]  = '{"divu_max_0",   OPDIVU, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, LAT_S};
    vecs[9]  = '{"rem_m5_0",     OPREM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, LAT_S};
    vecs[10] = '{"div_ovf",      OPDIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_S};
    vecs[11] = '{"rem_ovf",      OPREM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_S};
    vecs[12] = '{"divu_min_max", OPDIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_N};
    vecs[13] = '{"divu_max_1",   OPDIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, LAT_N};
    vecs[14] = '{"rem_min_3",    OPREM,  32'h8000_0000, 32'd3,         32'hFFFF_FFFE, LAT_N};
    vecs[15] = '{"div_m100_m7",  OPDIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        LAT_N};
    vecs[16] = '{"remu_max_16",  OPREMU, 32'hFFFF_FFFF, 32'd16,        32'd15,        LAT_N};
    vecs[17] = '{"div_min_2",    OPDIV,  32'h8000_0000, 32'd2,         32'hC000_0000, LAT_N};

    #3;
    check("reset_busy",   {31'd0, oBusy}, 32'd0);
    check("reset_done",   {31'd0, oDone}, 32'd0);
    check("reset_result", oResult,        32'd0);
    @(negedge iCLK);
    iRST_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      start_op(vecs[i].ctrl, vecs[i].a, vecs[i].b);
      if (vecs[i].lat == LAT_N) check({vecs[i].name, "_busy"}, {31'd0, oBusy}, 32'd1);
      wait_done(1, res, lat);
      check({vecs[i].name, "_result"}, res, vecs[i].exp);
      check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
    end

    // Flush on the edge of CALC step 10.
    prior = oResult;
    start_op(OPDIVU, 32'd1000, 32'd3);
    repeat (9) begin @(posedge iCLK); #1; end
    @(negedge iCLK); iFlush = 1'b1;
    @(posedge iCLK); #1; iFlush = 1'b0;
    check("flush_busy",   {31'd0, oBusy}, 32'd0);
    check("flush_done",   {31'd0, oDone}, 32'd0);
    check("flush_result", oResult,        prior);
    done_seen = 1'b0;
    repeat (40) begin @(posedge iCLK); #1; if (oDone) done_seen = 1'b1; end
    check("flush_no_done", {31'd0, done_seen}, 32'd0);
    start_op(OPDIVU, 32'd9, 32'd3);
    wait_done(1, res, lat);
    check("after_flush_result",  res, 32'd3);
    check("after_flush_latency", lat, LAT_N);

    // Asynchronous reset mid-CALC, taking effect without a clock edge.
    start_op(OPDIVU, 32'd100, 32'd7);
    repeat (5) begin @(posedge iCLK); #1; end
    #2 iRST_n = 1'b0;
    #1;
    check("rst_mid_busy",   {31'd0, oBusy}, 32'd0);
    check("rst_mid_done",   {31'd0, oDone}, 32'd0);
    check("rst_mid_result", oResult,        32'd0);
    @(negedge iCLK); iRST_n = 1'b1;
    start_op(OPDIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, res, lat);
    check("after_rst_result", res, 32'hFFFF_FFFD);

    // iStart while busy must not restart or queue an operation.
    start_op(OPDIVU, 32'd100, 32'd7);
    @(negedge iCLK);
    iStart = 1'b1; iControl = OPDIVU; iA = 32'd9; iB = 32'd3;
    lat = 1;
    repeat (3) begin @(posedge iCLK); #1; lat++; end
    iStart = 1'b0;
    wait_done(lat, res, lat);
    check("busy_start_result",  res, 32'd14);
    check("busy_start_latency", lat, LAT_N);

    // Non-divide op codes are ignored.
    @(negedge iCLK);
    iControl = OPADD; iA = 32'd1; iB = 32'd2; iStart = 1'b1;
    done_seen = 1'b0;
    repeat (3) begin @(posedge iCLK); #1; if (oBusy || oDone) done_seen = 1'b1; end
    iStart = 1'b0;
    check("opadd_ignored", {31'd0, done_seen}, 32'd0);
    check("opadd_result",  oResult,            32'd14);

    // Flush beats a simultaneous start in IDLE.
    @(negedge iCLK);
    iControl = OPDIVU; iA = 32'd9; iB = 32'd3; iStart = 1'b1; iFlush = 1'b1;
    @(posedge iCLK); #1;
    iStart = 1'b0; iFlush = 1'b0;
    check("flush_start_busy", {31'd0, oBusy}, 32'd0);

    // Flush in DONE: the visible pulse stays, then the unit returns to IDLE.
    start_op(OPDIV, 32'd5, 32'd0);
    check("done_flush_pulse", {31'd0, oDone}, 32'd1);
    @(negedge iCLK); iFlush = 1'b1;
    @(posedge iCLK); #1; iFlush = 1'b0;
    check("done_flush_done",   {31'd0, oDone}, 32'd0);
    check("done_flush_busy",   {31'd0, oBusy}, 32'd0);
    check("done_flush_result", oResult,        32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
